// File: rtl/axi_pkg.sv
// Shared AXI4 read-side encodings and state type for the read initiator.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_t;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_rd_rsp_buf.sv
// One-entry valid/ready holding register for returned read beats.
module axi_rd_rsp_buf #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_err,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_err
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_err;

  // Load wins over drain so a simultaneous load/drain keeps the entry valid with new data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_err   <= i_err;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_err   = r_err;

endmodule

// File: rtl/axi_rd_initiator.sv
// AXI4 read initiator: one outstanding INCR burst, beats returned through a
// one-entry buffer with per-beat error tagging.
//
// state | meaning
// IDLE  | req_ready high, waiting for a core request
// ADDR  | ARVALID high with latched payload, waiting for ARREADY
// DATA  | accepting R beats until RLAST
module axi_rd_initiator
  import axi_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] ID     = 4'h0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [7:0]        i_req_len,
  input  logic [2:0]        i_req_size,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_last,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_m_axi_araddr,
  output logic [7:0]        o_m_axi_arlen,
  output logic [2:0]        o_m_axi_arsize,
  output logic [1:0]        o_m_axi_arburst,
  output logic [3:0]        o_m_axi_arid,
  output logic              o_m_axi_arvalid,
  input  logic              i_m_axi_arready,
  input  logic [DATA_W-1:0] i_m_axi_rdata,
  input  logic [1:0]        i_m_axi_rresp,
  input  logic [3:0]        i_m_axi_rid,
  input  logic              i_m_axi_rlast,
  input  logic              i_m_axi_rvalid,
  output logic              o_m_axi_rready
);

  rd_state_t         r_state;
  logic              r_req_ready;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arsize;
  logic [1:0]        r_arburst;
  logic [7:0]        r_cnt;
  logic              r_past_len;

  logic w_buf_valid;
  logic w_rready;
  logic w_r_hs;
  logic w_cnt_is_len;
  logic w_err;

  // Accept R beats only in DATA and only when the buffer has room or is draining now.
  assign w_rready     = (r_state == DATA) && (!w_buf_valid || i_rsp_ready);
  assign w_r_hs       = i_m_axi_rvalid && w_rready;
  assign w_cnt_is_len = (r_cnt == r_arlen);
  // r_past_len keeps flagging beats once the subordinate has overrun ARLEN without RLAST.
  assign w_err        = resp_is_err(i_m_axi_rresp) || (i_m_axi_rid != ID) ||
                        (i_m_axi_rlast != w_cnt_is_len) || r_past_len;

  // Transaction sequencing, AR payload, beat counter and overrun flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arsize    <= '0;
      r_arburst   <= '0;
      r_cnt       <= '0;
      r_past_len  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (i_req_valid && r_req_ready) begin
            r_araddr    <= i_req_addr;
            r_arlen     <= i_req_len;
            r_arsize    <= i_req_size;
            r_arburst   <= BURST_INCR;
            r_cnt       <= '0;
            r_past_len  <= 1'b0;
            r_arvalid   <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= ADDR;
          end
        end
        ADDR: begin
          if (i_m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_r_hs) begin
            if (r_cnt != 8'hFF) begin
              r_cnt <= r_cnt + 8'd1;
            end
            if (w_cnt_is_len && !i_m_axi_rlast) begin
              r_past_len <= 1'b1;
            end
            if (i_m_axi_rlast) begin
              r_req_ready <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  axi_rd_rsp_buf #(
    .DATA_W (DATA_W)
  ) u_rsp_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_r_hs),
    .i_data  (i_m_axi_rdata),
    .i_last  (i_m_axi_rlast),
    .i_err   (w_err),
    .o_valid (w_buf_valid),
    .i_ready (i_rsp_ready),
    .o_data  (o_rsp_data),
    .o_last  (o_rsp_last),
    .o_err   (o_rsp_err)
  );

  assign o_req_ready     = r_req_ready;
  assign o_rsp_valid     = w_buf_valid;
  assign o_m_axi_araddr  = r_araddr;
  assign o_m_axi_arlen   = r_arlen;
  assign o_m_axi_arsize  = r_arsize;
  assign o_m_axi_arburst = r_arburst;
  assign o_m_axi_arid    = ID;
  assign o_m_axi_arvalid = r_arvalid;
  assign o_m_axi_rready  = w_rready;

endmodule

// File: doc/axi_rd_initiator.md
# axi_rd_initiator

AXI4 read-channel initiator (manager side) converting a simple core-side request/response stream into AXI4 AR/R transactions toward SoC read subordinates such as the CLINT mtime port or memory. Exactly one transaction outstanding; INCR bursts of 1..256 beats. Returned beats pass through a one-entry registered response buffer with per-beat error tagging, including protocol checks on RID and RLAST.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (RDATA and rsp_data)
- ID, 4'h0, constant ARID; expected RID
---
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when both high
- req_addr  in  ADDR_W  start byte address
- req_len  in  8  beats minus one (AXI ARLEN encoding)
- req_size  in  3  bytes per beat, log2 (AXI ARSIZE encoding)
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  response beat consumed when both high
- rsp_data  out  DATA_W  beat data
- rsp_last  out  1  final beat of transaction
- rsp_err  out  1  beat error (see Operation)
- M_AXI_ARADDR/ARLEN/ARSIZE/ARBURST/ARID  out  ADDR_W/8/3/2/4  AR payload
- M_AXI_ARVALID  out  1 ; M_AXI_ARREADY  in  1
- M_AXI_RDATA/RRESP/RID/RLAST  in  DATA_W/2/4/1  R payload
- M_AXI_RVALID  in  1 ; M_AXI_RREADY  out  1

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: req_ready=1. On req handshake, latch addr/len/size into AR registers, clear beat counter, go ADDR.
- ADDR: ARVALID=1; payload held stable until ARREADY. ARBURST=2'b01 (INCR), ARID=ID. On ARREADY go DATA. RREADY=0 in ADDR.
- DATA: RREADY = !buf_valid | rsp_ready. Each R handshake loads buffer with RDATA, RLAST, and err, and increments beat counter (8 bits).
- err = RRESP[1] | (RID != ID) | (RLAST != (count == len)).
- On R handshake with RLAST=1 go IDLE, independent of err. If RLAST is missing, stay in DATA and keep accepting beats; each beat past len is flagged err. The counter saturates at 255.
- Buffer: rsp_valid is set on load and cleared on rsp handshake without a simultaneous load. Load and drain in the same cycle keep rsp_valid=1 with the new data.
- IDLE may accept a new request while the buffer still holds the final beat. The next transaction's R beats stall on RREADY until that beat drains.
- RVALID in IDLE/ADDR is ignored (RREADY=0). No error is raised.

## Timing
- Reset values: req_ready=0 during reset, then 1 in IDLE. ARVALID=0, RREADY=0, rsp_valid=0, rsp_last=0, rsp_err=0, rsp_data=0, AR payload=0, state=IDLE.
- Req handshake at cycle N: ARVALID=1 at N+1. ARREADY at cycle M: RREADY may go high at M+1.
- Latency: R handshake at cycle K gives rsp_valid at K+1. Throughput is 1 beat/cycle with rsp_ready held high.
- Minimum single-beat round trip: req at N, AR handshake at N+1, R beat at N+2, rsp at N+3, next req_ready at N+3.
- Reset asserted mid-transaction: everything clears asynchronously and the in-flight burst is abandoned. After deassertion, ARVALID stays 0 until a new request.
- AXI rules: ARVALID never deasserts before ARREADY. ARVALID does not depend combinationally on ARREADY. RREADY may depend on rsp_ready.

## Structure
- Shared package axi_pkg:
  - BURST_INCR=2'b01
  - RESP_OKAY/EXOKAY/SLVERR/DECERR
  - rd_state_t enum {IDLE, ADDR, DATA}
- One sub-module, axi_rd_rsp_buf: a one-entry valid/ready holding register for {data, last, err}. The FSM, counter and error logic stay in the top level.

## Test plan
- Single read, len=0, addr=0x0200_BFF8, subordinate ARREADY=1 and RVALID=1 with RDATA=0x1234_5678, RLAST=1 -> one beat: rsp_data=0x1234_5678, rsp_last=1, rsp_err=0, at req cycle + 3.
- Burst len=3, ARREADY delayed 4 cycles, rsp_ready toggling 1/0 -> ARADDR/ARLEN stable while ARVALID=1; 4 beats in order; only beat 3 has rsp_last=1; no beat lost or duplicated.
- Early RLAST on beat 1 of len=3 -> that beat has rsp_err=1 and rsp_last=1; FSM returns to IDLE; req_ready=1 next cycle.
- RID=4'h5 with ID=0, RRESP=2'b10 on a separate beat -> each of those beats has rsp_err=1; data still delivered.
- Reset pulled low while in DATA after 2 of 4 beats -> all outputs at reset values within the same cycle; a post-reset single read completes normally.
- Back-to-back requests with rsp_ready=0 for 5 cycles -> the second AR issues, its RREADY stays 0 until the first final beat drains, then data flows at 1 beat/cycle.
